mem_port_arbiter: RTL and testbench

Shares the calculator's single-port SRAM between two requesters: requester 0, the calculator controller, and requester 1, a host/debug loader that preloads operands and drains results. The block chooses one requester per cycle and drives the memory port from the winner. It routes 1-cycle-latency read data back to the requester that issued the read. Optional burst locking lets a requester keep the port for back-to-back beats, with a bounded hold time so the other side cannot starve.

---
 rtl/calculator_pkg.sv | 16 +
 rtl/mem_port_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/calculator_pkg.sv
// Shared calculator parameters and the memory request payload.
//   ADDR_W        : word address width of the operand/result SRAM
//   MEM_WORD_SIZE : SRAM word width
//   mem_req_t     : one requester's write-enable, address and write data
package calculator_pkg;

  localparam int unsigned ADDR_W        = 8;
  localparam int unsigned MEM_WORD_SIZE = 64;

  typedef struct packed {
    logic                     we;
    logic [ADDR_W-1:0]        addr;
    logic [MEM_WORD_SIZE-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the calculator's single-port SRAM between the
// controller (requester 0) and the host/debug loader (requester 1).
//
// Ports (x = 0 controller, x = 1 host):
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   req_x, lock_x, we_x       request, keep-ownership request, write enable
//   addr_x, wdata_x           word address and write data
//   gnt_x                     combinational grant, transfer happens this edge
//   rvalid_x, rdata_x         read return, one cycle after a read grant
//   mem_read, mem_write       SRAM strobes from the granted requester
//   mem_addr, mem_wdata       SRAM address/data from the granted requester
//   mem_rdata                 SRAM read data, valid the cycle after mem_read
//   owner                     00 unlocked, 01 requester 0, 10 requester 1
//
// Build option: define MEM_ARB_RR_EN for round-robin contention resolution;
// otherwise requester 0 has fixed priority.
module mem_port_arbiter
  import calculator_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,

  input  logic                     req_0,
  input  logic                     lock_0,
  input  logic                     we_0,
  input  logic [ADDR_W-1:0]        addr_0,
  input  logic [MEM_WORD_SIZE-1:0] wdata_0,
  output logic                     gnt_0,
  output logic                     rvalid_0,
  output logic [MEM_WORD_SIZE-1:0] rdata_0,

  input  logic                     req_1,
  input  logic                     lock_1,
  input  logic                     we_1,
  input  logic [ADDR_W-1:0]        addr_1,
  input  logic [MEM_WORD_SIZE-1:0] wdata_1,
  output logic                     gnt_1,
  output logic                     rvalid_1,
  output logic [MEM_WORD_SIZE-1:0] rdata_1,

  output logic                     mem_read,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [MEM_WORD_SIZE-1:0] mem_wdata,
  input  logic [MEM_WORD_SIZE-1:0] mem_rdata,

  output logic [1:0]               owner
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned HOLD_W = CNT_W + 1;

  // Encoding doubles as the owner output.
  typedef enum logic [1:0] {
    ST_ARB  = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic               force_other_q, force_other_d;
  logic               force_id_q, force_id_d;
  logic               rd_pend_q, rd_pend_d;
  logic               rd_id_q, rd_id_d;

  logic               gnt0_c, gnt1_c;
  logic               win1_c;
  logic               prio_win1_c;
  logic               hold_expired_c;
  logic [CNT_W-1:0]   cnt_inc_c;
  mem_req_t           req0_s, req1_s, win_req_c;

  // Contention winner in ARB when no forced hand-over is pending.
`ifdef MEM_ARB_RR_EN
  logic last_gnt_q, last_gnt_d;

  assign prio_win1_c = ~last_gnt_q;

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt_1) begin
      last_gnt_d = 1'b1;
    end else if (gnt_0) begin
      last_gnt_d = 1'b0;
    end
  end

  // Resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_gnt_q <= 1'b1;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end
`else
  assign prio_win1_c = 1'b0;
`endif

  // Hold counter: saturating, advances every owned cycle.
  assign cnt_inc_c = (burst_cnt_q >= CNT_W'(MAX_BURST)) ? burst_cnt_q
                                                          : burst_cnt_q + CNT_W'(1);

  // Cycles held by the end of this one: the locking grant cycle, the owned
  // cycles already counted, and the current cycle. The '>=' keeps a saturated
  // counter from ever blocking the release.
  assign hold_expired_c = (HOLD_W'(burst_cnt_q) + HOLD_W'(2)) >= HOLD_W'(MAX_BURST);

  // Next-state and grant decode.
  always_comb begin
    state_d       = state_q;
    burst_cnt_d   = burst_cnt_q;
    force_other_d = 1'b0;
    force_id_d    = force_id_q;
    gnt0_c        = 1'b0;
    gnt1_c        = 1'b0;
    win1_c        = 1'b0;

    case (state_q)
      ST_ARB: begin
        if (req_0 && req_1) begin
          win1_c = force_other_q ? force_id_q : prio_win1_c;
        end else begin
          win1_c = req_1;
        end
        gnt0_c = req_0 & ~win1_c;
        gnt1_c = req_1 & win1_c;
        if (gnt0_c && lock_0) begin
          state_d     = ST_OWN0;
          burst_cnt_d = '0;
        end else if (gnt1_c && lock_1) begin
          state_d     = ST_OWN1;
          burst_cnt_d = '0;
        end
      end

      ST_OWN0: begin
        gnt0_c      = req_0;
        burst_cnt_d = cnt_inc_c;
        // A voluntary release takes precedence over a forced one.
        if (!lock_0) begin
          state_d = ST_ARB;
        end else if (req_1 && hold_expired_c) begin
          state_d       = ST_ARB;
          force_other_d = 1'b1;
          force_id_d    = 1'b1;
        end
      end

      ST_OWN1: begin
        gnt1_c      = req_1;
        burst_cnt_d = cnt_inc_c;
        if (!lock_1) begin
          state_d = ST_ARB;
        end else if (req_0 && hold_expired_c) begin
          state_d       = ST_ARB;
          force_other_d = 1'b1;
          force_id_d    = 1'b0;
        end
      end

      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  // Grants are suppressed while reset is asserted.
  assign gnt_0 = gnt0_c & rst_ni;
  assign gnt_1 = gnt1_c & rst_ni;

  // Memory port driven from the granted requester.
  assign req0_s    = '{we: we_0, addr: addr_0, wdata: wdata_0};
  assign req1_s    = '{we: we_1, addr: addr_1, wdata: wdata_1};
  assign win_req_c = gnt_1 ? req1_s : req0_s;

  assign mem_read  = (gnt_0 | gnt_1) & ~win_req_c.we;
  assign mem_write = (gnt_0 | gnt_1) &  win_req_c.we;
  assign mem_addr  = win_req_c.addr;
  assign mem_wdata = win_req_c.wdata;

  // Read return tracking.
  assign rd_pend_d = mem_read;
  assign rd_id_d   = gnt_1;

  assign rvalid_0 = rd_pend_q & ~rd_id_q;
  assign rvalid_1 = rd_pend_q &  rd_id_q;
  assign rdata_0  = mem_rdata;
  assign rdata_1  = mem_rdata;

  assign owner = 2'(state_q);

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_ARB;
      burst_cnt_q   <= '0;
      force_other_q <= 1'b0;
      force_id_q    <= 1'b0;
      rd_pend_q     <= 1'b0;
      rd_id_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      burst_cnt_q   <= burst_cnt_d;
      force_other_q <= force_other_d;
      force_id_q    <= force_id_d;
      rd_pend_q     <= rd_pend_d;
      rd_id_q       <= rd_id_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural SRAM and a read
// return scoreboard.
module tb_mem_port_arbiter;
  import calculator_pkg::*;

  localparam logic [63:0] D5 = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] D1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D2 = 64'hAAAA_BBBB_CCCC_DDDD;

  logic                     clk_i  = 1'b0;
  logic                     rst_ni = 1'b0;
  logic                     req_0 = 1'b0, lock_0 = 1'b0, we_0 = 1'b0;
  logic [ADDR_W-1:0]        addr_0 = '0;
  logic [MEM_WORD_SIZE-1:0] wdata_0 = '0;
  logic                     req_1 = 1'b0, lock_1 = 1'b0, we_1 = 1'b0;
  logic [ADDR_W-1:0]        addr_1 = '0;
  logic [MEM_WORD_SIZE-1:0] wdata_1 = '0;
  logic                     gnt_0, gnt_1, rvalid_0, rvalid_1;
  logic [MEM_WORD_SIZE-1:0] rdata_0, rdata_1;
  logic                     mem_read, mem_write;
  logic [ADDR_W-1:0]        mem_addr;
  logic [MEM_WORD_SIZE-1:0] mem_wdata;
  logic [MEM_WORD_SIZE-1:0] mem_rdata = '0;
  logic [1:0]               owner;

  logic [MEM_WORD_SIZE-1:0] mem [0:(2**ADDR_W)-1];

  typedef struct {
    logic        id;
    logic [63:0] data;
    int unsigned due;
  } rd_exp_t;

  rd_exp_t     sb[$];
  rd_exp_t     mon_e;
  int unsigned cyc    = 0;
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic        exp1;

  mem_port_arbiter #(.MAX_BURST(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_0(req_0), .lock_0(lock_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
    .gnt_0(gnt_0), .rvalid_0(rvalid_0), .rdata_0(rdata_0),
    .req_1(req_1), .lock_1(lock_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
    .gnt_1(gnt_1), .rvalid_1(rvalid_1), .rdata_1(rdata_1),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Single-port SRAM with one cycle read latency.
  always @(posedge clk_i) begin
    if (mem_read)  mem_rdata <= mem[mem_addr];
    if (mem_write) mem[mem_addr] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_read(input logic id, input logic [63:0] data);
    sb.push_back('{id: id, data: data, due: cyc + 1});
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_gnt(input string tag, input logic g0, input logic g1, input logic [1:0] own);
    check({tag, "_gnt_0"}, 64'(gnt_0), 64'(g0));
    check({tag, "_gnt_1"}, 64'(gnt_1), 64'(g1));
    check({tag, "_owner"}, 64'(owner), 64'(own));
  endtask

  // Read returns: compare due entries, otherwise no rvalid may appear.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        check("rvalid_0", 64'(rvalid_0), 64'(!mon_e.id));
        check("rvalid_1", 64'(rvalid_1), 64'(mon_e.id));
        check("rdata", mon_e.id ? rdata_1 : rdata_0, mon_e.data);
      end else begin
        check("rvalid_idle", 64'({rvalid_1, rvalid_0}), 64'(0));
      end
    end
  end

  initial begin
    mem[5] = D5;
    mem[1] = D1;
    mem[2] = D2;

    // Reset values, with a request pending.
    req_0 = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk_gnt("rst", 1'b0, 1'b0, 2'b00);
    check("rst_mem_read", 64'(mem_read), 64'(0));
    check("rst_mem_write", 64'(mem_write), 64'(0));
    check("rst_rvalid", 64'({rvalid_1, rvalid_0}), 64'(0));
    req_0  = 1'b0;
    rst_ni = 1'b1;
    tick();

    // Single read from the host.
    req_1 = 1'b1; we_1 = 1'b0; addr_1 = 8'd5;
    #1;
    chk_gnt("rd1", 1'b0, 1'b1, 2'b00);
    check("rd1_mem_read", 64'(mem_read), 64'(1));
    check("rd1_mem_addr", 64'(mem_addr), 64'(5));
    expect_read(1'b1, D5);
    tick();
    req_1 = 1'b0;
    #1;
    chk_gnt("rd1_idle", 1'b0, 1'b0, 2'b00);
    tick();

    // Contention without lock: back-to-back reads.
    req_0 = 1'b1; we_0 = 1'b0; addr_0 = 8'd1;
    req_1 = 1'b1; we_1 = 1'b0; addr_1 = 8'd2;
    for (int k = 0; k < 4; k++) begin
      #1;
`ifdef MEM_ARB_RR_EN
      exp1 = ((k % 2) == 1);
`else
      exp1 = 1'b0;
`endif
      chk_gnt("cont", !exp1, exp1, 2'b00);
      check("cont_mem_addr", 64'(mem_addr), exp1 ? 64'(2) : 64'(1));
      expect_read(exp1, exp1 ? D2 : D1);
      tick();
    end
    req_0 = 1'b0; req_1 = 1'b0;
    tick();

    // Host burst lock with the controller waiting: hand-over after 4 cycles.
    req_1 = 1'b1; lock_1 = 1'b1; we_1 = 1'b1; addr_1 = 8'd40; wdata_1 = 64'd7;
    #1;
    chk_gnt("burst0", 1'b0, 1'b1, 2'b00);
    check("burst0_mem_write", 64'(mem_write), 64'(1));
    check("burst0_mem_addr", 64'(mem_addr), 64'(40));
    tick();
    req_0 = 1'b1; we_0 = 1'b1; addr_0 = 8'd50; wdata_0 = 64'd9;
    for (int k = 1; k < 4; k++) begin
      #1;
      chk_gnt("burst_own", 1'b0, 1'b1, 2'b10);
      tick();
    end
    #1;
    chk_gnt("burst_handover", 1'b1, 1'b0, 2'b00);
    check("burst_handover_mem_addr", 64'(mem_addr), 64'(50));
    req_0 = 1'b0; req_1 = 1'b0; lock_1 = 1'b0;
    tick();

    // Controller lock, voluntary release with host pending.
    req_0 = 1'b1; lock_0 = 1'b1; we_0 = 1'b1; addr_0 = 8'd20;
    #1;
    chk_gnt("rel0", 1'b1, 1'b0, 2'b00);
    tick();
    req_1 = 1'b1; we_1 = 1'b1; addr_1 = 8'd21;
    #1;
    chk_gnt("rel1", 1'b1, 1'b0, 2'b01);
    tick();
    lock_0 = 1'b0;
    #1;
    chk_gnt("rel2", 1'b1, 1'b0, 2'b01);
    tick();
    req_0 = 1'b0;
    #1;
    chk_gnt("rel3", 1'b0, 1'b1, 2'b00);
    check("rel3_mem_addr", 64'(mem_addr), 64'(21));
    req_1 = 1'b0;
    tick();

    // Idle owner: counter saturates, late contender still gets through.
    req_0 = 1'b1; lock_0 = 1'b1; we_0 = 1'b1; addr_0 = 8'd60;
    #1;
    chk_gnt("sat0", 1'b1, 1'b0, 2'b00);
    tick();
    req_0 = 1'b0;
    for (int k = 1; k < 7; k++) begin
      #1;
      chk_gnt("sat_idle", 1'b0, 1'b0, 2'b01);
      tick();
    end
    req_1 = 1'b1; we_1 = 1'b1; addr_1 = 8'd61;
    #1;
    chk_gnt("sat_held", 1'b0, 1'b0, 2'b01);
    check("sat_held_mem_write", 64'(mem_write), 64'(0));
    tick();
    #1;
    chk_gnt("sat_forced", 1'b0, 1'b1, 2'b00);
    check("sat_forced_mem_addr", 64'(mem_addr), 64'(61));
    req_1 = 1'b0; lock_0 = 1'b0;
    tick();

    // Reset during an outstanding locked read.
    req_0 = 1'b1; lock_0 = 1'b1; we_0 = 1'b0; addr_0 = 8'd1;
    #1;
    chk_gnt("rstrd0", 1'b1, 1'b0, 2'b00);
    expect_read(1'b0, D1);
    tick();
    rst_ni = 1'b0;
    sb.delete();
    req_0 = 1'b0; lock_0 = 1'b0;
    #1;
    check("rstrd_rvalid", 64'({rvalid_1, rvalid_0}), 64'(0));
    check("rstrd_owner", 64'(owner), 64'(0));
    tick();
    rst_ni = 1'b1;
    req_0 = 1'b1; we_0 = 1'b1; addr_0 = 8'd3; wdata_0 = 64'h1234;
    #1;
    chk_gnt("post_rst", 1'b1, 1'b0, 2'b00);
    check("post_rst_mem_write", 64'(mem_write), 64'(1));
    check("post_rst_mem_read", 64'(mem_read), 64'(0));
    check("post_rst_mem_addr", 64'(mem_addr), 64'(3));
    check("post_rst_mem_wdata", mem_wdata, 64'h1234);
    tick();
    req_0 = 1'b0;
    #1;
    check("post_rst_mem3", mem[3], 64'h1234);
    tick();
    tick();
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
